// File: rtl/fc_acc_ctrl.sv
// Sequencer for one fully-connected layer pass: bias load, operand reads, pipeline drain, done.
// Define FC_ACC_CTRL_CYCLE_COUNT_EN to add a saturating 16-bit busy-cycle counter output.
module fc_acc_ctrl #(
  parameter int unsigned N_INPUTS   = 84,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned PIPE_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  src_valid,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  bias_sel,
  output logic                  enable_write,
  output logic                  busy,
  output logic                  done
`ifdef FC_ACC_CTRL_CYCLE_COUNT_EN
  ,
  output logic [15:0]           cycle_count
`endif
);

  typedef enum logic [2:0] {StIdle, StBias, StIssue, StDrain, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(N_INPUTS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [PIPE_LAT-1:0]   vld_q, vld_d, vld_shift;

  // Valid bits of reads in flight; the MSB lines up with the product at the accumulator.
  assign vld_shift    = vld_q << 1;
  assign vld_d        = vld_shift | PIPE_LAT'(rd_en);
  assign enable_write = vld_q[PIPE_LAT-1];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_en    = 1'b0;
    rd_addr  = '0;
    bias_sel = 1'b0;
    done     = 1'b0;
    busy     = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StBias;
      end
      StBias: begin
        bias_sel = 1'b1;
        idx_d    = '0;
        state_d  = StIssue;
      end
      StIssue: begin
        rd_en   = src_valid;
        rd_addr = idx_q;
        if (src_valid) begin
          // Index parks on the last address rather than wrapping.
          if (idx_q == LastIdx) state_d = StDrain;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      StDrain: begin
        // Leave once the final valid bit shifts out of the pipe.
        if (vld_shift == '0) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef FC_ACC_CTRL_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && start)    cnt_d = '0;
    else if (busy && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_fc_acc_ctrl.sv
// Bench for fc_acc_ctrl: an N_INPUTS=4/PIPE_LAT=2 and an N_INPUTS=1/PIPE_LAT=1 instance
// share stimulus; per-pass expectations come from an event-level model of the pass timeline.
module tb_fc_acc_ctrl;
  localparam int AW   = 7;
  localparam int MAXC = 64;

  logic clk;
  logic reset, start, src_valid;
  logic a_rd_en, a_bias, a_we, a_busy, a_done;
  logic b_rd_en, b_bias, b_we, b_busy, b_done;
  logic [AW-1:0] a_addr, b_addr;
  logic sel_b;
  logic o_rd_en, o_bias, o_we, o_busy, o_done;
  logic [AW-1:0] o_addr;
`ifdef FC_ACC_CTRL_CYCLE_COUNT_EN
  logic [15:0] a_cc, b_cc, o_cc;
`endif

  int checks   = 0;
  int failures = 0;

  int vpat  [MAXC];
  int e_rd  [MAXC];
  int e_addr[MAXC];
  int e_bias[MAXC];
  int e_we  [MAXC];
  int e_busy[MAXC];
  int e_done[MAXC];

  fc_acc_ctrl #(.N_INPUTS(4), .ADDR_WIDTH(AW), .PIPE_LAT(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .src_valid(src_valid),
    .rd_en(a_rd_en), .rd_addr(a_addr), .bias_sel(a_bias), .enable_write(a_we),
    .busy(a_busy), .done(a_done)
`ifdef FC_ACC_CTRL_CYCLE_COUNT_EN
    , .cycle_count(a_cc)
`endif
  );

  fc_acc_ctrl #(.N_INPUTS(1), .ADDR_WIDTH(AW), .PIPE_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .src_valid(src_valid),
    .rd_en(b_rd_en), .rd_addr(b_addr), .bias_sel(b_bias), .enable_write(b_we),
    .busy(b_busy), .done(b_done)
`ifdef FC_ACC_CTRL_CYCLE_COUNT_EN
    , .cycle_count(b_cc)
`endif
  );

  assign o_rd_en = sel_b ? b_rd_en : a_rd_en;
  assign o_addr  = sel_b ? b_addr  : a_addr;
  assign o_bias  = sel_b ? b_bias  : a_bias;
  assign o_we    = sel_b ? b_we    : a_we;
  assign o_busy  = sel_b ? b_busy  : a_busy;
  assign o_done  = sel_b ? b_done  : a_done;
`ifdef FC_ACC_CTRL_CYCLE_COUNT_EN
  assign o_cc    = sel_b ? b_cc    : a_cc;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int cy, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cy, obs, exp);
    end
  endtask

  // One pass: start at cycle 0, bias at 1, reads from 2 on whenever src_valid, each write
  // PIPE_LAT after its read, done PIPE_LAT+1 after the last read, idle on the cycle after.
  task automatic run_pass(input bit use_b, input int mode, input bit extra, input int abort_at);
    int  n, pl, issued, c, done_c, last;
    bit  ab;
    n      = use_b ? 1 : 4;
    pl     = use_b ? 1 : 2;
    sel_b  = use_b;
    for (int i = 0; i < MAXC; i++) begin
      case (mode)
        0:       vpat[i] = 1;
        1:       vpat[i] = (i == 3 || i == 4) ? 0 : 1;
        default: vpat[i] = (i > 40) ? 1 : int'($urandom_range(0, 3) != 0);
      endcase
      e_rd[i] = 0; e_addr[i] = 0; e_bias[i] = 0; e_we[i] = 0; e_busy[i] = 0; e_done[i] = 0;
    end
    e_bias[1] = 1;
    e_busy[1] = 1;
    issued    = 0;
    c         = 2;
    while (issued < n) begin
      e_busy[c] = 1;
      e_addr[c] = issued;
      if (vpat[c] != 0) begin
        e_rd[c]      = 1;
        e_we[c + pl] = 1;
        issued++;
      end
      c++;
    end
    done_c = c + pl;
    for (int i = c; i <= done_c; i++) e_busy[i] = 1;
    e_done[done_c] = 1;
    last = done_c + 1;

    for (int cy = 0; cy <= last; cy++) begin
      @(posedge clk);
      #1;
      reset = (cy == abort_at);
      if (abort_at >= 0 && cy >= abort_at) start = (cy == abort_at);
      else start = (cy == 0) || (extra && cy >= 2 && cy <= done_c && $urandom_range(0, 2) == 0);
      src_valid = (vpat[cy] != 0);
      @(negedge clk);
      ab = (abort_at >= 0 && cy > abort_at);
      check("rd_en",        cy, 32'(o_rd_en), ab ? 0 : e_rd[cy]);
      check("rd_addr",      cy, 32'(o_addr),  ab ? 0 : e_addr[cy]);
      check("bias_sel",     cy, 32'(o_bias),  ab ? 0 : e_bias[cy]);
      check("enable_write", cy, 32'(o_we),    ab ? 0 : e_we[cy]);
      check("busy",         cy, 32'(o_busy),  ab ? 0 : e_busy[cy]);
      check("done",         cy, 32'(o_done),  ab ? 0 : e_done[cy]);
`ifdef FC_ACC_CTRL_CYCLE_COUNT_EN
      if (cy >= 1)
        check("cycle_count", cy, 32'(o_cc), ab ? 0 : (cy <= done_c ? cy - 1 : done_c));
`endif
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    src_valid = 1'b0;
    sel_b     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start     = 1'b1;
    src_valid = 1'b1;
    @(negedge clk);
    check("reset_rd_en",   0, 32'(a_rd_en), 0);
    check("reset_rd_addr", 0, 32'(a_addr),  0);
    check("reset_bias",    0, 32'(a_bias),  0);
    check("reset_we",      0, 32'(a_we),    0);
    check("reset_busy",    0, 32'(a_busy),  0);
    check("reset_done",    0, 32'(a_done),  0);
    check("reset_b_busy",  0, 32'(b_busy),  0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    start     = 1'b0;
    src_valid = 1'b0;

    run_pass(1'b0, 0, 1'b0, -1);   // src_valid held high
    run_pass(1'b0, 1, 1'b0, -1);   // bubbles at cycles 3-4
    run_pass(1'b0, 0, 1'b1, -1);   // stray starts mid-pass
    run_pass(1'b0, 0, 1'b0, 4);    // reset (with start) at cycle 4
    run_pass(1'b0, 0, 1'b0, -1);   // clean pass after abort
    repeat (12) run_pass(1'b0, 2, 1'b1, -1);
    run_pass(1'b0, 2, 1'b0, 6);

    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_pass(1'b1, 0, 1'b0, -1);
    repeat (6) run_pass(1'b1, 2, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_acc_ctrl.md
FC_ACC_CTRL -- requirements
Module: fc_acc_ctrl

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 84, giving the number of input activations accumulated per FC pass (at least 1).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 7, giving the read-address width; it must be at least clog2(N_INPUTS).
REQ-003 The block SHALL have parameter PIPE_LAT, default 2, giving the cycles from read issue to the product being valid at the accumulator inputs (at least 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: a pulse that requests one FC pass.
REQ-007 The block SHALL have port src_valid, input, 1 bit: the operand source can accept a read this cycle.
REQ-008 The block SHALL have port rd_en, output, 1 bit: a read is issued this cycle.
REQ-009 The block SHALL have port rd_addr, output, ADDR_WIDTH bits: the input/weight index being read.
REQ-010 The block SHALL have port bias_sel, output, 1 bit: load the bias into all accumulators.
REQ-011 The block SHALL have port enable_write, output, 1 bit: accumulate the current products.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the pass completes.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, BIAS, ISSUE, DRAIN and DONE.
REQ-015 In IDLE with start=1, the FSM SHALL move to BIAS; start SHALL be ignored in all other states.
REQ-016 BIAS SHALL last exactly one cycle with bias_sel=1, enable_write=0 and rd_en=0, then the FSM SHALL move to ISSUE with the index set to 0.
REQ-017 In ISSUE, rd_en SHALL equal src_valid combinationally, and rd_addr SHALL equal the current index.
REQ-018 In ISSUE, the index SHALL increment only on cycles where rd_en=1; when src_valid=0 the index SHALL hold and a bubble SHALL enter the pipeline.
REQ-019 The rd_en of every issue cycle SHALL enter a PIPE_LAT-deep valid shift register, and enable_write SHALL equal its output, so enable_write is rd_en delayed by exactly PIPE_LAT cycles, bubbles included.
REQ-020 When the read at index N_INPUTS-1 is issued, the FSM SHALL move to DRAIN; the index SHALL never exceed N_INPUTS-1 and SHALL never wrap.
REQ-021 DRAIN SHALL keep rd_en=0 and SHALL move to DONE on the cycle after the shift register holds no valid bits, i.e. after the last enable_write.
REQ-022 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-023 Over one pass, enable_write SHALL be high on exactly N_INPUTS cycles.
REQ-024 bias_sel and enable_write SHALL never both be 1 in the same cycle.
REQ-025 rd_addr SHALL be 0 whenever the FSM is not in ISSUE.
REQ-026 With N_INPUTS=1, the pass SHALL be BIAS, one issue, PIPE_LAT cycles of DRAIN, then DONE.

Reset
REQ-027 With reset=1 at a clock edge, the block SHALL enter IDLE and SHALL clear the index, the shift register and any cycle counter.
REQ-028 Reset values SHALL be: rd_en=0, rd_addr=0, bias_sel=0, enable_write=0, busy=0, done=0.
REQ-029 A reset in the middle of a pass SHALL abort it: no further enable_write and no done pulse, with reset taking priority over start.

Configuration
REQ-030 When macro FC_ACC_CTRL_CYCLE_COUNT_EN is defined, the block SHALL add output cycle_count (16 bits).
REQ-031 cycle_count SHALL clear on entry to BIAS, increment on every busy cycle, saturate at 16'hFFFF, and hold its value after DONE until the next start.
REQ-032 When FC_ACC_CTRL_CYCLE_COUNT_EN is not defined, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Verification (N_INPUTS=4, PIPE_LAT=2 unless stated)
REQ-033 Start pulse, src_valid held at 1: bias_sel at cycle 1, rd_addr 0,1,2,3 at cycles 2-5, enable_write at cycles 4-7, done at cycle 8, busy at cycles 1-8.
REQ-034 Start pulse, src_valid=0 at cycles 3-4: the index holds at 1, enable_write shows a 2-cycle gap at cycles 5-6, and done is 2 cycles later than in REQ-033.
REQ-035 Start pulses during ISSUE and DRAIN: no effect, with exactly one bias_sel and exactly 4 enable_write cycles.
REQ-036 Reset at cycle 4 of a pass: all outputs are 0 the next cycle, with no done pulse; a following start runs a full clean pass.
REQ-037 N_INPUTS=1, PIPE_LAT=1: bias_sel at cycle 1, rd_en at cycle 2, enable_write at cycle 3, done at cycle 4.
REQ-038 With FC_ACC_CTRL_CYCLE_COUNT_EN defined, the REQ-033 stimulus leaves cycle_count=8 after done, and it resets to 1 after the next BIAS cycle.
